regfile_alu_pipe: RTL and testbench
===================================

Name: regfile_alu_pipe

Overview:
Parametrised successor to the combined register-file/ALU execute block. It adds a registered writeback stage with operand forwarding and a wider ALU op set. It also adds an iterative shift-add multiplier, which stalls issue through a valid/ready handshake. It sits between decode (rs1/rs2/rd/ImmOp/ALUctrl) and the PC/branch logic (EQ, next_PC).

Parameters:
ADDRESS_WIDTH, 5, register index width; the file holds 2**ADDRESS_WIDTH registers.
DATA_WIDTH, 32, register/operand/result width; must be a power of two, at least 8.
A0_INDEX, 10, register index mirrored on the a0 output.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  instruction presented this cycle.
in_ready  out  1  block can accept; an instruction issues on in_valid && in_ready at the clk edge.
ALUctrl  in  4  operation select.
ALUsrc  in  1  1: op2 = ImmOp; 0: op2 = forwarded rs2 value.
ImmOp  in  DATA_WIDTH  immediate.
rs1, rs2, rd  in  ADDRESS_WIDTH  register indices.
RegWrite  in  1  write the result to rd.
jumpSaveNext  in  1  result = next_PC instead of the ALU output.
next_PC  in  DATA_WIDTH  link value.
EQ  out  1  combinational: forwarded op1 == selected op2.
wb_valid  out  1  writeback stage holds a result this cycle.
wb_rd  out  ADDRESS_WIDTH  writeback destination.
wb_data  out  DATA_WIDTH  writeback data.
busy  out  1  multiplier FSM not IDLE.
a0  out  DATA_WIDTH  architectural register A0_INDEX; regfile contents, not forwarded.

Behaviour:
- Reset (async, immediate): all registers cleared to 0; wb_valid=0, wb_rd=0, wb_data=0; FSM=IDLE; busy=0; in_ready=1; a0=0. A multiply in progress when reset asserts is aborted and produces no write.
- Register x0 reads as 0. Writes to x0 are dropped; a write to x0 never sets the forwarding match.
- Operand read is combinational with forwarding. If wb_valid && wb_we && wb_rd==rsN && rsN!=0, the operand is wb_data; otherwise it is regfile[rsN].
- ALUctrl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT: signed compare, result 1/0.
  - 0110 SLL, 0111 SRL: shift by op2[log2(DATA_WIDTH)-1:0].
  - 1000 MUL: low DATA_WIDTH bits of the product.
  - 1001-1111: result 0.
- All arithmetic wraps modulo 2**DATA_WIDTH.
- Single-cycle ops, including any op with jumpSaveNext=1, which never starts the multiplier. On an issue at edge N, the writeback stage loads at edge N: wb_valid=1, wb_we=RegWrite, wb_rd, wb_data. The regfile write happens at edge N+1. With no issue at an edge, wb_valid clears to 0.
- MUL FSM:
  - IDLE: on an issue with ALUctrl=1000 and jumpSaveNext=0, latch op1, op2, rd and RegWrite; clear the accumulator and counter; go to MUL.
  - MUL: in_ready=0; one shift-add step per cycle for DATA_WIDTH cycles.
  - On the final step: load the writeback stage with the product (wb_valid=1) and return to IDLE.
  - Issue at edge N gives a writeback load at edge N+DATA_WIDTH and the regfile write at edge N+DATA_WIDTH+1.
  - in_ready returns to 1 in the cycle after the final step.
- Back-to-back: an instruction issued while the writeback stage holds a result for its rsN receives the forwarded value. Consecutive dependent single-cycle ops therefore run at one per cycle with no stall.
- in_valid while in_ready=0 is ignored. The sender holds the instruction until accepted.
- EQ is meaningful only while in_valid=1 and is computed from the forwarded operands.

Test Plan:
- Reset mid-operation: write x5=7, issue MUL, assert rst after 3 cycles -> all wb outputs and a0 read 0, busy=0, in_ready=1; x5 reads 0 afterwards.
- Forwarding: ADDI x1=x0+5 (ALUsrc=1, ImmOp=5), then next cycle ADD x2=x1+x1 -> wb_data=10 one cycle later; x2=10 committed; no stall.
- x0 protection: ADDI x0=x0+9, then ADD x3=x0+x0 -> wb_data=0; EQ=1 on the second instruction.
- MUL timing (DATA_WIDTH=32): x1=0xFFFF_FFFF, x2=3, MUL x10 -> in_ready low for 32 cycles; wb_data=0xFFFF_FFFD at edge N+32; a0=0xFFFF_FFFD after edge N+33.
- Ops/boundaries: SUB 0-1 = 0xFFFF_FFFF; SLT(-1,1)=1; SLL 1 by op2=33 -> 2; ALUctrl=1111 -> 0.
- Link: jumpSaveNext=1, next_PC=0x104, rd=1, ALUctrl=1000 -> single-cycle, x1=0x104, busy stays 0.

Source files
------------

// File: rtl/regfile_alu_pipe.sv
// Register file + ALU execute block with registered writeback, operand forwarding and iterative multiplier.
// Latency: single-cycle ops load writeback at the issue edge; MUL loads writeback DATA_WIDTH edges after issue.
// Backpressure: in_ready drops while the multiplier runs; in_valid is ignored until in_ready returns high.
module regfile_alu_pipe #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int A0_INDEX      = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               ALUctrl,
  input  logic                     ALUsrc,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic                     RegWrite,
  input  logic                     jumpSaveNext,
  input  logic [DATA_WIDTH-1:0]    next_PC,
  output logic                     EQ,
  output logic                     wb_valid,
  output logic [ADDRESS_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0]           CNT_LAST = SHW'(DATA_WIDTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(A0_INDEX);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   regs [NREG];
  logic                    wb_we;

  logic [DATA_WIDTH-1:0]   op1, rs2_val, op2;
  logic [DATA_WIDTH-1:0]   alu_res, result;
  logic                    issue, start_mul, mul_last;

  // multiplier datapath: multiplicand shifts left, multiplier shifts right
  logic [DATA_WIDTH-1:0]   m_acc, m_cand, m_plier, mul_sum;
  logic [SHW-1:0]          m_cnt;
  logic [ADDRESS_WIDTH-1:0] m_rd;
  logic                    m_we;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_MUL);
  assign issue     = in_valid && in_ready;
  assign start_mul = issue && (ALUctrl == 4'b1000) && !jumpSaveNext;
  assign mul_last  = (state == S_MUL) && (m_cnt == CNT_LAST);
  assign mul_sum   = m_acc + (m_plier[0] ? m_cand : '0);
  assign a0        = regs[A0_IDX];

  // operand read: x0 is hardwired zero, otherwise bypass from writeback when it targets the same register
  always_comb begin
    op1     = '0;
    rs2_val = '0;
    if (rs1 != '0)
      op1 = (wb_valid && wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
    if (rs2 != '0)
      rs2_val = (wb_valid && wb_we && wb_rd == rs2) ? wb_data : regs[rs2];
    op2 = ALUsrc ? ImmOp : rs2_val;
  end

  assign EQ = (op1 == op2);

  // single-cycle ALU; MUL is produced by the iterative unit, undefined codes give zero
  always_comb begin
    alu_res = '0;
    case (ALUctrl)
      4'b0000: alu_res = op1 + op2;
      4'b0001: alu_res = op1 - op2;
      4'b0010: alu_res = op1 & op2;
      4'b0011: alu_res = op1 | op2;
      4'b0100: alu_res = op1 ^ op2;
      4'b0101: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'b0110: alu_res = op1 << op2[SHW-1:0];
      4'b0111: alu_res = op1 >> op2[SHW-1:0];
      default: alu_res = '0;
    endcase
    result = jumpSaveNext ? next_PC : alu_res;
  end

  // register file commits whatever the writeback stage held in the previous cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_valid && wb_we && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // multiplier FSM: latch operands on issue, then one shift-add step per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      m_acc   <= '0;
      m_cand  <= '0;
      m_plier <= '0;
      m_cnt   <= '0;
      m_rd    <= '0;
      m_we    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mul) begin
            m_cand  <= op1;
            m_plier <= op2;
            m_acc   <= '0;
            m_cnt   <= '0;
            m_rd    <= rd;
            m_we    <= RegWrite;
            state   <= S_MUL;
          end
        end
        S_MUL: begin
          m_acc   <= mul_sum;
          m_cand  <= m_cand << 1;
          m_plier <= m_plier >> 1;
          m_cnt   <= m_cnt + 1'b1;
          if (m_cnt == CNT_LAST) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // writeback stage: loaded by a single-cycle issue or the final multiply step, otherwise invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (issue && !start_mul) begin
      wb_valid <= 1'b1;
      wb_we    <= RegWrite;
      wb_rd    <= rd;
      wb_data  <= result;
    end else if (mul_last) begin
      wb_valid <= 1'b1;
      wb_we    <= m_we;
      wb_rd    <= m_rd;
      wb_data  <= mul_sum;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
module tb_regfile_alu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALUctrl = '0;
  logic        ALUsrc = 1'b0;
  logic [31:0] ImmOp = '0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        RegWrite = 1'b0;
  logic        jumpSaveNext = 1'b0;
  logic [31:0] next_PC = '0;
  logic        EQ;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [31:0] a0;

  int tests = 0;
  int fails = 0;

  // architectural model: register values as seen by program order
  logic [31:0] mreg [32];

  regfile_alu_pipe #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .A0_INDEX(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmOp(ImmOp),
    .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite),
    .jumpSaveNext(jumpSaveNext), .next_PC(next_PC), .EQ(EQ),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .a0(a0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
  endfunction

  function automatic logic [31:0] rv(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : mreg[r];
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic jsn, input logic [31:0] npc);
    if (jsn) return npc;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << (b % 32);
      4'd7: return a >> (b % 32);
      4'd8: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void commit(input logic [4:0] d, input logic we, input logic [31:0] v);
    if (we && d != 5'd0) mreg[d] = v;
  endfunction

  task automatic drive(input logic [3:0] op, input logic src, input logic [31:0] imm,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic we, input logic jsn, input logic [31:0] npc);
    @(negedge clk);
    ALUctrl = op; ALUsrc = src; ImmOp = imm; rs1 = r1; rs2 = r2; rd = d;
    RegWrite = we; jumpSaveNext = jsn; next_PC = npc; in_valid = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    tests++; if (wb_rd !== 5'd0) begin fails++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
    tests++; if (wb_data !== 32'd0) begin fails++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL reset_hs busy=%b in_ready=%b want 0/1", busy, in_ready); end
    tests++; if (a0 !== 32'd0) begin fails++; $display("FAIL reset_a0 got %h want 0", a0); end
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic test_forwarding();
    drive(4'd0, 1'b1, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'd0);
    step();
    tests++; if (wb_valid !== 1'b1 || wb_data !== 32'd5 || wb_rd !== 5'd1) begin fails++; $display("FAIL fwd_addi got v=%b rd=%0d d=%h want 1/1/5", wb_valid, wb_rd, wb_data); end
    drive(4'd0, 1'b0, 32'd0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 32'd0);
    tests++; if (in_ready !== 1'b1 || EQ !== 1'b1) begin fails++; $display("FAIL fwd_nostall in_ready=%b EQ=%b want 1/1", in_ready, EQ); end
    step();
    tests++; if (wb_data !== 32'd10 || wb_rd !== 5'd2) begin fails++; $display("FAIL fwd_add got rd=%0d d=%h want 2/a", wb_rd, wb_data); end
    step();
    drive(4'd0, 1'b0, 32'd0, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0);
    step();
    tests++; if (wb_data !== 32'd10) begin fails++; $display("FAIL fwd_commit x2 got %h want a", wb_data); end
    commit(5'd1, 1'b1, 32'd5); commit(5'd2, 1'b1, 32'd10); commit(5'd7, 1'b1, 32'd10);
  endtask

  task automatic test_x0();
    drive(4'd0, 1'b1, 32'd9, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'd0);
    tests++; if (EQ !== 1'b1) begin fails++; $display("FAIL x0_eq got %b want 1", EQ); end
    step();
    tests++; if (wb_data !== 32'd0) begin fails++; $display("FAIL x0_read got %h want 0", wb_data); end
    commit(5'd3, 1'b1, 32'd0);
  endtask

  task automatic test_ops();
    drive(4'd1, 1'b1, 32'd1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'd0);
    step();
    tests++; if (wb_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sub_wrap got %h want ffffffff", wb_data); end
    drive(4'd5, 1'b1, 32'd1, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 32'd0);
    step();
    tests++; if (wb_data !== 32'd1) begin fails++; $display("FAIL slt_signed got %h want 1", wb_data); end
    drive(4'd6, 1'b1, 32'd33, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'd0);
    step();
    tests++; if (wb_data !== 32'd2) begin fails++; $display("FAIL sll_33 got %h want 2", wb_data); end
    drive(4'd15, 1'b1, 32'h1234, 5'd4, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0);
    step();
    tests++; if (wb_data !== 32'd0) begin fails++; $display("FAIL op_1111 got %h want 0", wb_data); end
    commit(5'd4, 1'b1, 32'hFFFF_FFFF); commit(5'd5, 1'b1, 32'd1);
    commit(5'd6, 1'b1, 32'd2); commit(5'd7, 1'b1, 32'd0);
  endtask

  task automatic test_link();
    drive(4'd8, 1'b0, 32'd0, 5'd2, 5'd2, 5'd1, 1'b1, 1'b1, 32'h104);
    step();
    tests++; if (wb_valid !== 1'b1 || wb_data !== 32'h104 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL link got v=%b d=%h busy=%b rdy=%b want 1/104/0/1", wb_valid, wb_data, busy, in_ready); end
    drive(4'd0, 1'b0, 32'd0, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 32'd0);
    step();
    tests++; if (wb_data !== 32'h104) begin fails++; $display("FAIL link_fwd x1 got %h want 104", wb_data); end
    commit(5'd1, 1'b1, 32'h104); commit(5'd8, 1'b1, 32'h104);
  endtask

  task automatic test_mul_timing();
    int lat, low;
    drive(4'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'd0, 1'b1, 32'd3, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'd8, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 32'd0);
    step();
    // present another instruction while the multiplier runs; it must wait
    ALUctrl = 4'd0; ALUsrc = 1'b1; ImmOp = 32'h55; rs1 = 5'd0; rd = 5'd11; RegWrite = 1'b1; in_valid = 1'b1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mul_busy got %b want 1", busy); end
    lat = 0;
    low = (in_ready == 1'b0) ? 1 : 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (wb_valid) lat = k;
      else if (!in_ready) low++;
    end
    tests++; if (lat != 32) begin fails++; $display("FAIL mul_latency got %0d want 32", lat); end
    tests++; if (low != 32) begin fails++; $display("FAIL mul_stall_cycles got %0d want 32", low); end
    tests++; if (wb_data !== 32'hFFFF_FFFD || wb_rd !== 5'd10) begin fails++; $display("FAIL mul_result got rd=%0d d=%h want 10/fffffffd", wb_rd, wb_data); end
    @(posedge clk); #1; in_valid = 1'b0;
    tests++; if (a0 !== 32'hFFFF_FFFD) begin fails++; $display("FAIL mul_a0 got %h want fffffffd", a0); end
    tests++; if (wb_valid !== 1'b1 || wb_rd !== 5'd11 || wb_data !== 32'h55) begin fails++; $display("FAIL held_issue got v=%b rd=%0d d=%h want 1/11/55", wb_valid, wb_rd, wb_data); end
    commit(5'd1, 1'b1, 32'hFFFF_FFFF); commit(5'd2, 1'b1, 32'd3);
    commit(5'd10, 1'b1, 32'hFFFF_FFFD); commit(5'd11, 1'b1, 32'h55);
  endtask

  task automatic test_reset_mid_mul();
    drive(4'd0, 1'b1, 32'd7, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'd0);
    step();
    drive(4'd8, 1'b0, 32'd0, 5'd5, 5'd5, 5'd10, 1'b1, 1'b0, 32'd0);
    step();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    tests++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || a0 !== 32'd0) begin
      fails++; $display("FAIL midrst_outputs got v=%b rd=%0d d=%h a0=%h want zeros", wb_valid, wb_rd, wb_data, a0); end
    tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midrst_hs busy=%b rdy=%b want 0/1", busy, in_ready); end
    @(negedge clk); rst = 1'b0;
    model_reset();
    low_check: begin
      int seen = 0;
      repeat (40) begin @(posedge clk); #1; if (wb_valid) seen++; end
      tests++; if (seen != 0 || a0 !== 32'd0) begin fails++; $display("FAIL midrst_abort wb_valid_cycles=%0d a0=%h want 0/0", seen, a0); end
    end
    drive(4'd0, 1'b0, 32'd0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'd0);
    step();
    tests++; if (wb_data !== 32'd0) begin fails++; $display("FAIL midrst_x5 got %h want 0", wb_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic        src, we, jsn, is_mul;
      logic [31:0] imm, npc, a, b, exp;
      logic [4:0]  r1, r2, d;
      int          lat;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd8 && $urandom_range(0, 3) != 0) op = 4'd0;
      src = 1'($urandom_range(0, 1));
      imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r1 = 5'($urandom_range(0, 8)); if (r1 == 5'd8) r1 = 5'd10;
      r2 = 5'($urandom_range(0, 8)); if (r2 == 5'd8) r2 = 5'd10;
      d  = 5'($urandom_range(0, 8)); if (d == 5'd8) d = 5'd10;
      we  = ($urandom_range(0, 7) != 0);
      jsn = ($urandom_range(0, 7) == 0);
      npc = $urandom;
      a = rv(r1);
      b = src ? imm : rv(r2);
      exp = ref_res(op, a, b, jsn, npc);
      is_mul = (op == 4'd8) && !jsn;
      drive(op, src, imm, r1, r2, d, we, jsn, npc);
      tests++; if (EQ !== (a == b)) begin fails++; $display("FAIL rnd_eq[%0d] got %b want %b", n, EQ, (a == b)); end
      step();
      if (is_mul) begin
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin @(posedge clk); #1; if (wb_valid) lat = k; end
        tests++; if (lat != 32) begin fails++; $display("FAIL rnd_mul_lat[%0d] got %0d want 32", n, lat); end
      end
      tests++; if (wb_valid !== 1'b1 || wb_rd !== d || wb_data !== exp) begin
        fails++; $display("FAIL rnd_wb[%0d] op=%0d got v=%b rd=%0d d=%h want 1/%0d/%h", n, op, wb_valid, wb_rd, wb_data, d, exp); end
      commit(d, we, exp);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        tests++; if (a0 !== mreg[10]) begin fails++; $display("FAIL rnd_a0[%0d] got %h want %h", n, a0, mreg[10]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forwarding();
    test_x0();
    test_ops();
    test_link();
    test_mul_timing();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
